// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch front end: FSM state codes,
// opcode constants and default address/instruction widths.
package fetch_controller_pkg;

   localparam int DEFAULT_ADDR = 20;
   localparam int DEFAULT_BITS = 32;

   typedef logic [1:0] fetch_state_t;

   localparam logic [1:0] ST_BOOT   = 2'd0;
   localparam logic [1:0] ST_FETCH  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;
   localparam logic [1:0] ST_FAULT  = 2'd3;

   localparam logic [5:0] OP_JMP = 6'd8;
   localparam logic [5:0] OP_HLT = 6'd12;

   function automatic logic is_halt(input logic [5:0] opcode, input logic [5:0] hlt_op);
      return (opcode == hlt_op);
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding {pc, instruction} pairs between fetch and decode.
// Only pointers and count are reset; the head reads as zero when empty.
module fetch_buffer
   import fetch_controller_pkg::*;
#(
   parameter int WIDTH = DEFAULT_ADDR + DEFAULT_BITS
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_r [2];
   logic             wptr_r;
   logic             rptr_r;
   logic [1:0]       count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Guard the handshakes so a misuse can never corrupt the occupancy
   always_comb begin
      pop_ok_s  = pop && !empty && !flush;
      push_ok_s = push && (!full || pop_ok_s) && !flush;
   end

   // Entry storage, written at the write pointer
   always_ff @(posedge clock) begin
      if (push_ok_s) begin
         mem_r[wptr_r] <= wdata;
      end
   end

   // Pointer and occupancy tracking; a flush empties the buffer
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr_r  <= 1'b0;
         rptr_r  <= 1'b0;
         count_r <= 2'd0;
      end else if (flush) begin
         wptr_r  <= 1'b0;
         rptr_r  <= 1'b0;
         count_r <= 2'd0;
      end else begin
         if (push_ok_s) wptr_r <= ~wptr_r;
         if (pop_ok_s)  rptr_r <= ~rptr_r;
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign full  = (count_r == 2'd2);
   assign empty = (count_r == 2'd0);
   assign rdata = empty ? {WIDTH{1'b0}} : mem_r[rptr_r];

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks pc through instruction memory, buffers
// fetched words for decode, and handles redirect, halt and out-of-range fault.
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter int         ADDR      = DEFAULT_ADDR,
   parameter int         BITS      = DEFAULT_BITS,
   parameter int         SIZE      = 150,
   parameter int         BOOT_ADDR = 0,
   parameter logic [5:0] HLT_OP    = OP_HLT
) (
   input  logic            clock,
   input  logic            reset,
   output logic [ADDR-1:0] imem_address,
   input  logic [BITS-1:0] imem_instruction,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [BITS-1:0] instr_word,
   output logic [ADDR-1:0] instr_pc,
   input  logic            redirect_valid,
   input  logic [ADDR-1:0] redirect_target,
   input  logic            resume,
   output logic            halted,
   output logic            fetch_fault
);

   localparam int              ENTRY_W = ADDR + BITS;
   localparam logic [ADDR:0]   LIMIT   = (ADDR + 1)'(SIZE);
   localparam logic [ADDR-1:0] BOOT_PC = ADDR'(BOOT_ADDR);

   fetch_state_t      state_r;
   fetch_state_t      next_state_s;
   logic [ADDR-1:0]   pc_r;
   logic [ADDR-1:0]   next_pc_s;
   logic              in_range_s;
   logic              push_s;
   logic              pop_s;
   logic              full_s;
   logic              empty_s;
   logic [ENTRY_W-1:0] head_s;
   logic              halted_r;
   logic              fault_r;

   // Handshakes and next-state decode; redirect overrides everything
   always_comb begin
      in_range_s   = ({1'b0, pc_r} < LIMIT);
      pop_s        = !empty_s && instr_ready && !redirect_valid;
      push_s       = (state_r == ST_FETCH) && in_range_s && (!full_s || pop_s) && !redirect_valid;
      next_state_s = state_r;
      next_pc_s    = pc_r;
      if (redirect_valid) begin
         next_state_s = ST_FETCH;
         next_pc_s    = redirect_target;
      end else begin
         if (push_s) begin
            next_pc_s = pc_r + ADDR'(1'b1);
         end else begin
            next_pc_s = pc_r;
         end
         case (state_r)
            ST_BOOT: next_state_s = ST_FETCH;
            ST_FETCH: begin
               if (!in_range_s) begin
                  next_state_s = ST_FAULT;
               end else if (push_s && is_halt(imem_instruction[BITS-1 -: 6], HLT_OP)) begin
                  next_state_s = ST_HALTED;
               end else begin
                  next_state_s = ST_FETCH;
               end
            end
            ST_HALTED: begin
               if (resume) begin
                  next_state_s = ST_FETCH;
               end else begin
                  next_state_s = ST_HALTED;
               end
            end
            ST_FAULT: next_state_s = ST_FAULT;
            default:  next_state_s = ST_BOOT;
         endcase
      end
   end

   // State, pc and the registered status flags
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r  <= ST_BOOT;
         pc_r     <= BOOT_PC;
         halted_r <= 1'b0;
         fault_r  <= 1'b0;
      end else begin
         state_r  <= next_state_s;
         pc_r     <= next_pc_s;
         halted_r <= (next_state_s == ST_HALTED);
         fault_r  <= (next_state_s == ST_FAULT);
      end
   end

   fetch_buffer #(
      .WIDTH (ENTRY_W)
   ) u_buffer (
      .clock (clock),
      .reset (reset),
      .flush (redirect_valid),
      .push  (push_s),
      .pop   (pop_s),
      .wdata ({pc_r, imem_instruction}),
      .rdata (head_s),
      .full  (full_s),
      .empty (empty_s)
   );

   assign imem_address = pc_r;
   assign instr_valid  = !empty_s;
   assign instr_pc     = head_s[ENTRY_W-1 -: ADDR];
   assign instr_word   = head_s[BITS-1:0];
   assign halted       = halted_r;
   assign fetch_fault  = fault_r;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed, table-driven bench for fetch_controller with a behavioural
// instruction memory (HLT at address 79, all other words tagged with their address).
module tb_fetch_controller;

   logic        clock;
   logic        reset;
   logic [19:0] imem_address;
   logic [31:0] imem_instruction;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_word;
   logic [19:0] instr_pc;
   logic        redirect_valid;
   logic [19:0] redirect_target;
   logic        resume;
   logic        halted;
   logic        fetch_fault;

   int passed;
   int total;

   typedef struct {
      logic        ready;
      logic        redir;
      logic [19:0] target;
      logic        res;
      logic        exp_valid;
      logic [19:0] exp_pc;
      logic [19:0] exp_addr;
      logic        exp_halted;
      logic        exp_fault;
   } vec_t;

   vec_t vecs [$];

   fetch_controller dut (
      .clock            (clock),
      .reset            (reset),
      .imem_address     (imem_address),
      .imem_instruction (imem_instruction),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .instr_word       (instr_word),
      .instr_pc         (instr_pc),
      .redirect_valid   (redirect_valid),
      .redirect_target  (redirect_target),
      .resume           (resume),
      .halted           (halted),
      .fetch_fault      (fetch_fault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [19:0] a);
      if (a == 20'd79) return {6'd12, 26'd0};
      return {6'd1, 6'd0, a};
   endfunction

   assign imem_instruction = mem_word(imem_address);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rdy, input logic rd, input logic [19:0] tg, input logic rs,
                      input logic v, input logic [19:0] pc, input logic [19:0] ad,
                      input logic h, input logic f);
      vec_t e;
      e.ready = rdy; e.redir = rd; e.target = tg; e.res = rs;
      e.exp_valid = v; e.exp_pc = pc; e.exp_addr = ad; e.exp_halted = h; e.exp_fault = f;
      vecs.push_back(e);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      reset = 1'b0;
      instr_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = 20'd0;
      resume = 1'b0;

      // ready, redir, target, resume | valid, head pc, imem_address, halted, fault
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b0, 20'd0,   20'd0,   1'b0, 1'b0); // 0 after BOOT
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b1, 20'd0,   20'd1,   1'b0, 1'b0);
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b1, 20'd1,   20'd2,   1'b0, 1'b0);
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b1, 20'd2,   20'd3,   1'b0, 1'b0);
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b1, 20'd3,   20'd4,   1'b0, 1'b0);
      add(1'b0, 1'b1, 20'd0,   1'b0,  1'b1, 20'd4,   20'd5,   1'b0, 1'b0); // 5 restart at 0
      add(1'b0, 1'b0, 20'd0,   1'b0,  1'b0, 20'd0,   20'd0,   1'b0, 1'b0);
      add(1'b0, 1'b0, 20'd0,   1'b0,  1'b1, 20'd0,   20'd1,   1'b0, 1'b0);
      add(1'b0, 1'b0, 20'd0,   1'b0,  1'b1, 20'd0,   20'd2,   1'b0, 1'b0);
      add(1'b0, 1'b0, 20'd0,   1'b0,  1'b1, 20'd0,   20'd2,   1'b0, 1'b0);
      add(1'b0, 1'b0, 20'd0,   1'b0,  1'b1, 20'd0,   20'd2,   1'b0, 1'b0); // 10 stalled, full
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b1, 20'd0,   20'd2,   1'b0, 1'b0);
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b1, 20'd1,   20'd3,   1'b0, 1'b0);
      add(1'b0, 1'b1, 20'd50,  1'b0,  1'b1, 20'd2,   20'd4,   1'b0, 1'b0); // 13 redirect when full
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b0, 20'd0,   20'd50,  1'b0, 1'b0);
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b1, 20'd50,  20'd51,  1'b0, 1'b0);
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b1, 20'd51,  20'd52,  1'b0, 1'b0);
      add(1'b1, 1'b1, 20'd77,  1'b0,  1'b1, 20'd52,  20'd53,  1'b0, 1'b0); // 17 towards HLT
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b0, 20'd0,   20'd77,  1'b0, 1'b0);
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b1, 20'd77,  20'd78,  1'b0, 1'b0);
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b1, 20'd78,  20'd79,  1'b0, 1'b0);
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b1, 20'd79,  20'd80,  1'b1, 1'b0); // 21 HLT delivered
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b0, 20'd0,   20'd80,  1'b1, 1'b0);
      add(1'b1, 1'b0, 20'd0,   1'b1,  1'b0, 20'd0,   20'd80,  1'b1, 1'b0); // 23 resume
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b0, 20'd0,   20'd80,  1'b0, 1'b0);
      add(1'b1, 1'b0, 20'd0,   1'b1,  1'b1, 20'd80,  20'd81,  1'b0, 1'b0); // 25 stray resume
      add(1'b1, 1'b1, 20'd148, 1'b0,  1'b1, 20'd81,  20'd82,  1'b0, 1'b0);
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b0, 20'd0,   20'd148, 1'b0, 1'b0);
      add(1'b0, 1'b0, 20'd0,   1'b0,  1'b1, 20'd148, 20'd149, 1'b0, 1'b0);
      add(1'b0, 1'b0, 20'd0,   1'b0,  1'b1, 20'd148, 20'd150, 1'b0, 1'b0);
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b1, 20'd148, 20'd150, 1'b0, 1'b1); // 30 drain in FAULT
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b1, 20'd149, 20'd150, 1'b0, 1'b1);
      add(1'b1, 1'b1, 20'd0,   1'b0,  1'b0, 20'd0,   20'd150, 1'b0, 1'b1);
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b0, 20'd0,   20'd0,   1'b0, 1'b0);
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b1, 20'd0,   20'd1,   1'b0, 1'b0);
      add(1'b1, 1'b1, 20'hFFFFF, 1'b0, 1'b1, 20'd1,  20'd2,   1'b0, 1'b0); // 35 far out of range
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b0, 20'd0,   20'hFFFFF, 1'b0, 1'b0);
      add(1'b1, 1'b0, 20'd0,   1'b0,  1'b0, 20'd0,   20'hFFFFF, 1'b0, 1'b1);

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("rst valid", 64'(instr_valid), 64'd0);
      check("rst halted", 64'(halted), 64'd0);
      check("rst fault", 64'(fetch_fault), 64'd0);
      check("rst word", 64'(instr_word), 64'd0);
      check("rst pc", 64'(instr_pc), 64'd0);
      check("rst addr", 64'(imem_address), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         instr_ready     = vecs[i].ready;
         redirect_valid  = vecs[i].redir;
         redirect_target = vecs[i].target;
         resume          = vecs[i].res;
         @(negedge clock);
         check($sformatf("row%0d valid", i), 64'(instr_valid), 64'(vecs[i].exp_valid));
         check($sformatf("row%0d addr", i), 64'(imem_address), 64'(vecs[i].exp_addr));
         check($sformatf("row%0d halted", i), 64'(halted), 64'(vecs[i].exp_halted));
         check($sformatf("row%0d fault", i), 64'(fetch_fault), 64'(vecs[i].exp_fault));
         if (vecs[i].exp_valid) begin
            check($sformatf("row%0d pc", i), 64'(instr_pc), 64'(vecs[i].exp_pc));
            check($sformatf("row%0d word", i), 64'(instr_word), 64'(mem_word(vecs[i].exp_pc)));
         end
         @(posedge clock);
         #1;
      end
      redirect_valid = 1'b0;
      resume = 1'b0;

      // Reset while in FAULT: the flag drops without waiting for a clock
      #2;
      reset = 1'b0;
      #1;
      check("async fault drop", 64'(fetch_fault), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      instr_ready = 1'b0;
      @(posedge clock);
      #1;
      @(negedge clock);
      check("boot valid", 64'(instr_valid), 64'd0);
      check("boot addr", 64'(imem_address), 64'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("full valid", 64'(instr_valid), 64'd1);
      check("full pc", 64'(instr_pc), 64'd0);
      check("full addr", 64'(imem_address), 64'd2);

      // Reset with two entries buffered discards them asynchronously
      #1;
      reset = 1'b0;
      #1;
      check("async valid drop", 64'(instr_valid), 64'd0);
      check("async word zero", 64'(instr_word), 64'd0);
      check("async pc zero", 64'(instr_pc), 64'd0);
      check("async addr", 64'(imem_address), 64'd0);
      #1;
      reset = 1'b1;
      instr_ready = 1'b1;
      @(posedge clock);
      #1;
      check("rerun boot valid", 64'(instr_valid), 64'd0);
      @(posedge clock);
      @(negedge clock);
      check("rerun valid", 64'(instr_valid), 64'd1);
      check("rerun pc", 64'(instr_pc), 64'd0);
      check("rerun addr", 64'(imem_address), 64'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
